// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetch/decode/execute controller driving the control word of an 8-register datapath.
// Latency: 2 cycles per instruction (FETCH + EXEC). LD/ST add one cycle for each cycle that mem_ack is withheld.
// Backpressure: the mem_req/mem_ack handshake stalls the sequencer for as long as needed. Nothing else stalls it.
// Ports: clk/reset (async active-low); start leaves IDLE; instr_in is the instruction at pc_out.
//        control_word = {DA,AA,BA,MB,FS,MD,RW}; constant_out feeds the datapath immediate.
//        flag_* are the datapath V/C/N/Z; mem_req/mem_we/mem_ack form the data memory handshake; halted is high in HALT.
module datapath_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr_in,
    output logic [7:0]  pc_out,
    output logic [15:0] control_word,
    output logic [7:0]  constant_out,
    input  logic        flag_v,
    input  logic        flag_c,
    input  logic        flag_n,
    input  logic        flag_z,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5, OP_NOT = 4'h6, OP_MOV = 4'h7, OP_ADI = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9, OP_LD  = 4'hA, OP_ST  = 4'hB, OP_BZ  = 4'hC;
    localparam logic [3:0] OP_BNZ = 4'hD, OP_JMP = 4'hE, OP_HLT = 4'hF;

    localparam logic [3:0] FS_MOVA = 4'b0000, FS_ADD = 4'b0010, FS_SUB = 4'b0101, FS_AND = 4'b1000;
    localparam logic [3:0] FS_OR   = 4'b1001, FS_XOR = 4'b1010, FS_NOT = 4'b1011, FS_MOVB = 4'b1100;

    state_t      state, state_nxt;
    logic [7:0]  pc, pc_nxt;
    logic [15:0] ir, ir_nxt;
    logic [3:0]  flags, flags_nxt;      // {v,c,n,z}

    logic [3:0]  op;
    logic [2:0]  dr, sa, sb;
    logic [7:0]  imm, tgt;

    logic [2:0]  da, aa, ba;
    logic        mb, md, rw;
    logic [3:0]  fs;
    logic        alu_op, mem_phase;

    // V, C and N are latched alongside Z for future conditional branches; only Z is consulted today.
    logic        flags_unused;
    assign flags_unused = ^flags[3:1];

    assign op  = ir[15:12];
    assign dr  = ir[11:9];
    assign sa  = ir[8:6];
    assign sb  = ir[5:3];
    assign imm = {2'b00, ir[5:0]};
    assign tgt = ir[7:0];

    assign pc_out       = pc;
    assign control_word = {da, aa, ba, mb, fs, md, rw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            flags <= flags_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = ir;
        flags_nxt    = flags;
        da           = '0;
        aa           = '0;
        ba           = '0;
        mb           = 1'b0;
        fs           = FS_MOVA;
        md           = 1'b0;
        rw           = 1'b0;
        constant_out = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        halted       = 1'b0;
        alu_op       = 1'b0;
        mem_phase    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_nxt    = instr_in;
                pc_nxt    = pc + 8'd1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (op)
                    OP_ADD: begin alu_op = 1'b1; fs = FS_ADD;  end
                    OP_SUB: begin alu_op = 1'b1; fs = FS_SUB;  end
                    OP_AND: begin alu_op = 1'b1; fs = FS_AND;  end
                    OP_OR:  begin alu_op = 1'b1; fs = FS_OR;   end
                    OP_XOR: begin alu_op = 1'b1; fs = FS_XOR;  end
                    OP_NOT: begin alu_op = 1'b1; fs = FS_NOT;  end
                    OP_MOV: begin alu_op = 1'b1; fs = FS_MOVA; end
                    OP_ADI: begin alu_op = 1'b1; fs = FS_ADD;  mb = 1'b1; constant_out = imm; end
                    OP_LDI: begin alu_op = 1'b1; fs = FS_MOVB; mb = 1'b1; constant_out = imm; end
                    OP_LD, OP_ST: mem_phase = 1'b1;
                    // PC already holds the incremented value; a taken branch overrides it.
                    OP_BZ:  if (flags[0])  pc_nxt = tgt;
                    OP_BNZ: if (!flags[0]) pc_nxt = tgt;
                    OP_JMP: pc_nxt = tgt;
                    OP_HLT: state_nxt = S_HALT;
                    default: ;  // NOP
                endcase
            end
            S_MEM_WAIT: mem_phase = 1'b1;
            S_HALT:     halted = 1'b1;
            default:    state_nxt = S_IDLE;
        endcase

        if (alu_op) begin
            da        = dr;
            aa        = sa;
            ba        = sb;
            rw        = 1'b1;
            flags_nxt = {flag_v, flag_c, flag_n, flag_z};
        end

        // The memory word is identical in EXEC and MEM_WAIT, so an ack in EXEC completes with no wait cycle.
        // A load writes the register file only in the cycle that the load data is valid.
        if (mem_phase) begin
            aa      = sa;
            ba      = sb;
            mem_req = 1'b1;
            mem_we  = (op == OP_ST);
            if (op == OP_LD) begin
                da = dr;
                md = 1'b1;
                rw = mem_ack;
            end
            state_nxt = mem_ack ? S_FETCH : S_MEM_WAIT;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

    logic        clk, reset, start, mem_ack;
    logic        flag_v, flag_c, flag_n, flag_z;
    logic [15:0] instr_in, control_word;
    logic [7:0]  pc_out, constant_out;
    logic        mem_req, mem_we, halted;

    logic [15:0] imem [0:255];
    int tests_run = 0;
    int tests_failed = 0;

    assign instr_in = imem[pc_out];

    datapath_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
        .pc_out(pc_out), .control_word(control_word), .constant_out(constant_out),
        .flag_v(flag_v), .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: expected control word of the execute/memory cycle of one instruction, from the opcode table.
    function automatic logic [15:0] exp_word(input logic [15:0] ins, input logic ack);
        logic [3:0] op;
        logic [2:0] dr, sa, sb;
        logic [3:0] fs;
        op = ins[15:12]; dr = ins[11:9]; sa = ins[8:6]; sb = ins[5:3];
        case (op)
            4'h1, 4'h8: fs = 4'b0010;
            4'h2:       fs = 4'b0101;
            4'h3:       fs = 4'b1000;
            4'h4:       fs = 4'b1001;
            4'h5:       fs = 4'b1010;
            4'h6:       fs = 4'b1011;
            4'h9:       fs = 4'b1100;
            default:    fs = 4'b0000;
        endcase
        if (op >= 4'h1 && op <= 4'h9) return {dr, sa, sb, (op >= 4'h8), fs, 1'b0, 1'b1};
        if (op == 4'hA) return {dr, sa, sb, 1'b0, 4'b0000, 1'b1, ack};
        if (op == 4'hB) return {3'd0, sa, sb, 7'd0};
        return 16'h0000;
    endfunction

    function automatic logic [7:0] exp_const(input logic [15:0] ins);
        if (ins[15:12] == 4'h8 || ins[15:12] == 4'h9) return {2'b00, ins[5:0]};
        return 8'h00;
    endfunction

    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    // Pulses reset, releases it with start=1 and returns inside the first FETCH cycle.
    task automatic boot;
        start = 1'b0; mem_ack = 1'b0;
        {flag_v, flag_c, flag_n, flag_z} = 4'h0;
        reset = 1'b1; #1; reset = 1'b0;
        cyc(); cyc();
        reset = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset;
        clear_mem();
        start = 1'b1; mem_ack = 1'b0;
        {flag_v, flag_c, flag_n, flag_z} = 4'h0;
        reset = 1'b1; #1; reset = 1'b0;
        cyc(); cyc();
        tests_run++; if (pc_out !== 8'h00) begin tests_failed++; $display("FAIL reset_pc: got %h expected 00", pc_out); end
        tests_run++; if (control_word !== 16'h0000) begin tests_failed++; $display("FAIL reset_cw: got %h expected 0000", control_word); end
        tests_run++; if (constant_out !== 8'h00) begin tests_failed++; $display("FAIL reset_const: got %h expected 00", constant_out); end
        tests_run++; if ({mem_req, mem_we, halted} !== 3'b000) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 000", {mem_req, mem_we, halted}); end
        start = 1'b0; reset = 1'b1;
        cyc(); cyc();
        tests_run++; if (pc_out !== 8'h00 || control_word !== 16'h0000) begin tests_failed++; $display("FAIL idle_hold: got pc %h cw %h expected 00 0000", pc_out, control_word); end
    endtask

    task automatic test_alu_seq;
        clear_mem();
        imem[0] = 16'h9205; imem[1] = 16'h9403; imem[2] = 16'h1650; imem[3] = 16'hF000;
        boot();
        tests_run++; if (pc_out !== 8'h00 || control_word !== 16'h0000) begin tests_failed++; $display("FAIL fetch0: got pc %h cw %h expected 00 0000", pc_out, control_word); end
        cyc();
        tests_run++; if (control_word !== 16'h2071 || constant_out !== 8'h05) begin tests_failed++; $display("FAIL ldi1_word: got %h/%h expected 2071/05", control_word, constant_out); end
        cyc(); cyc();
        tests_run++; if (control_word !== 16'h4071 || constant_out !== 8'h03) begin tests_failed++; $display("FAIL ldi2_word: got %h/%h expected 4071/03", control_word, constant_out); end
        cyc();
        tests_run++; if (pc_out !== 8'h02) begin tests_failed++; $display("FAIL fetch2_pc: got %h expected 02", pc_out); end
        cyc();
        tests_run++; if (control_word !== 16'h6509 || constant_out !== 8'h00) begin tests_failed++; $display("FAIL add_word: got %h/%h expected 6509/00", control_word, constant_out); end
        cyc();
        tests_run++; if (pc_out !== 8'h03 || control_word !== 16'h0000) begin tests_failed++; $display("FAIL fetch3: got pc %h cw %h expected 03 0000", pc_out, control_word); end
    endtask

    task automatic test_branch;
        clear_mem();
        imem[8'h00] = 16'h2848; imem[8'h01] = 16'hC020;
        imem[8'h20] = 16'h2848; imem[8'h21] = 16'hC040; imem[8'h22] = 16'hF000;
        boot();
        cyc();
        flag_z = 1'b1; #1;
        tests_run++; if (control_word !== 16'h8495) begin tests_failed++; $display("FAIL sub_word: got %h expected 8495", control_word); end
        cyc();
        flag_z = 1'b0;
        cyc();
        tests_run++; if (control_word !== 16'h0000) begin tests_failed++; $display("FAIL bz_word: got %h expected 0000", control_word); end
        cyc();
        tests_run++; if (pc_out !== 8'h20) begin tests_failed++; $display("FAIL bz_taken: got pc %h expected 20", pc_out); end
        cyc();
        flag_z = 1'b0;
        cyc();
        flag_z = 1'b1;  // live flag must not matter, only the latched one
        cyc();
        tests_run++; if (pc_out !== 8'h22) begin tests_failed++; $display("FAIL bz_not_taken: got pc %h expected 22", pc_out); end
        flag_z = 1'b0;
    endtask

    task automatic test_mem;
        int req_cycles;
        clear_mem();
        imem[0] = 16'hAA40; imem[1] = 16'hB098; imem[2] = 16'hF000;
        boot();
        cyc();
        req_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3); #1;
            if (mem_req === 1'b1) req_cycles++;
            tests_run++;
            if (control_word !== ((k == 3) ? 16'hA403 : 16'hA402) || mem_we !== 1'b0) begin
                tests_failed++; $display("FAIL ld_cycle%0d: got cw %h we %b expected %h 0", k, control_word, mem_we, (k == 3) ? 16'hA403 : 16'hA402);
            end
            cyc();
        end
        mem_ack = 1'b0; #1;
        tests_run++; if (req_cycles != 4) begin tests_failed++; $display("FAIL ld_req_len: got %0d expected 4", req_cycles); end
        tests_run++; if (mem_req !== 1'b0 || pc_out !== 8'h01) begin tests_failed++; $display("FAIL ld_done: got req %b pc %h expected 0 01", mem_req, pc_out); end
        cyc();
        mem_ack = 1'b1; #1;
        tests_run++; if (control_word !== 16'h0980 || mem_req !== 1'b1 || mem_we !== 1'b1) begin tests_failed++; $display("FAIL st_word: got %h req %b we %b expected 0980 1 1", control_word, mem_req, mem_we); end
        cyc();
        mem_ack = 1'b0; #1;
        tests_run++; if (mem_req !== 1'b0 || pc_out !== 8'h02) begin tests_failed++; $display("FAIL st_no_wait: got req %b pc %h expected 0 02", mem_req, pc_out); end
    endtask

    task automatic test_pc_wrap;
        clear_mem();
        imem[8'h00] = 16'hE0FF; imem[8'hFF] = 16'h0000;
        boot();
        cyc();
        tests_run++; if (control_word !== 16'h0000 || pc_out !== 8'h01) begin tests_failed++; $display("FAIL jmp_exec: got cw %h pc %h expected 0000 01", control_word, pc_out); end
        cyc();
        tests_run++; if (pc_out !== 8'hFF) begin tests_failed++; $display("FAIL jmp_target: got %h expected ff", pc_out); end
        cyc(); cyc();
        tests_run++; if (pc_out !== 8'h00) begin tests_failed++; $display("FAIL pc_wrap: got %h expected 00", pc_out); end
    endtask

    task automatic test_halt;
        clear_mem();
        imem[0] = 16'hF000;
        boot();
        cyc();
        tests_run++; if (halted !== 1'b0 || control_word !== 16'h0000) begin tests_failed++; $display("FAIL hlt_exec: got halted %b cw %h expected 0 0000", halted, control_word); end
        cyc();
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom); #1;
            tests_run++;
            if (halted !== 1'b1 || control_word !== 16'h0000 || mem_req !== 1'b0 || pc_out !== 8'h01) begin
                tests_failed++; $display("FAIL halt_hold%0d: got halted %b cw %h pc %h expected 1 0000 01", i, halted, control_word, pc_out);
            end
            cyc();
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset;
        clear_mem();
        imem[0] = 16'hAA40;
        boot();
        cyc();
        cyc();
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL wait_req: got %b expected 1", mem_req); end
        #1 reset = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b0 || pc_out !== 8'h00 || control_word !== 16'h0000) begin tests_failed++; $display("FAIL async_rst: got req %b pc %h cw %h expected 0 00 0000", mem_req, pc_out, control_word); end
        cyc();
        reset = 1'b1;
        cyc(); cyc();
        tests_run++; if (pc_out !== 8'h00 || mem_req !== 1'b0 || control_word !== 16'h0000) begin tests_failed++; $display("FAIL rst_idle: got pc %h req %b cw %h expected 00 0 0000", pc_out, mem_req, control_word); end
    endtask

    task automatic test_random;
        logic [7:0]  mpc;
        logic        mz;
        logic [15:0] ins;
        logic [3:0]  op, fl;
        int          d;
        for (int i = 0; i < 256; i++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'h0;
            imem[i] = ins;
        end
        mpc = 8'h00; mz = 1'b0;
        boot();
        for (int n = 0; n < 300; n++) begin
            mem_ack = 1'($urandom); #1;
            tests_run++;
            if (pc_out !== mpc || control_word !== 16'h0000 || mem_req !== 1'b0) begin
                tests_failed++; $display("FAIL rnd_fetch%0d: got pc %h cw %h req %b expected %h 0000 0", n, pc_out, control_word, mem_req, mpc);
            end
            ins = imem[mpc]; op = ins[15:12]; mpc = mpc + 8'd1;
            cyc();
            if (op == 4'hA || op == 4'hB) begin
                d = $urandom_range(0, 3);
                for (int k = 0; k <= d; k++) begin
                    mem_ack = (k == d);
                    {flag_v, flag_c, flag_n, flag_z} = 4'($urandom); #1;
                    tests_run++;
                    if (control_word !== exp_word(ins, k == d) || mem_req !== 1'b1 || mem_we !== (op == 4'hB)) begin
                        tests_failed++; $display("FAIL rnd_mem%0d: ins %h got cw %h req %b we %b expected %h", n, ins, control_word, mem_req, mem_we, exp_word(ins, k == d));
                    end
                    cyc();
                end
            end else begin
                fl = 4'($urandom);
                {flag_v, flag_c, flag_n, flag_z} = fl;
                mem_ack = 1'($urandom); #1;
                tests_run++;
                if (control_word !== exp_word(ins, 1'b0) || constant_out !== exp_const(ins) || mem_req !== 1'b0) begin
                    tests_failed++; $display("FAIL rnd_exec%0d: ins %h got cw %h k %h expected %h %h", n, ins, control_word, constant_out, exp_word(ins, 1'b0), exp_const(ins));
                end
                if (op >= 4'h1 && op <= 4'h9) mz = fl[0];
                if ((op == 4'hC && mz) || (op == 4'hD && !mz) || op == 4'hE) mpc = ins[7:0];
                cyc();
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
        {flag_v, flag_c, flag_n, flag_z} = 4'h0;
        test_reset();
        test_alu_seq();
        test_branch();
        test_mem();
        test_pc_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
